// File: rtl/player_cmd_gen.sv
// Per-player command generator: keycodes -> facing, paced moves, fire.
// Two identical channels, one per player, no cross-player coupling.
module player_cmd_gen #(
  parameter int REPEAT_FRAMES   = 4,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [7:0] keycode_p1,
  input  logic [7:0] keycode_p2,
  output logic [1:0] p1_dir,
  output logic [1:0] p2_dir,
  output logic       p1_move,
  output logic       p2_move,
  output logic       p1_fire,
  output logic       p2_fire,
  output logic       p1_busy,
  output logic       p2_busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } mv_st_t;

  localparam logic [7:0] RLOAD = 8'(REPEAT_FRAMES - 1);
  localparam logic [7:0] CLOAD = 8'(COOLDOWN_FRAMES);

  logic [1:0][7:0] w_key;
  logic [1:0][1:0] w_dir;
  logic [1:0]      w_move;
  logic [1:0]      w_fire;
  logic [1:0]      w_busy;

  assign w_key[0] = keycode_p1;
  assign w_key[1] = keycode_p2;

  assign p1_dir  = w_dir[0];
  assign p2_dir  = w_dir[1];
  assign p1_move = w_move[0];
  assign p2_move = w_move[1];
  assign p1_fire = w_fire[0];
  assign p2_fire = w_fire[1];
  assign p1_busy = w_busy[0];
  assign p2_busy = w_busy[1];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam logic [7:0] K_UP   = (g == 0) ? 8'h1a : 8'h52;
    localparam logic [7:0] K_DN   = (g == 0) ? 8'h16 : 8'h51;
    localparam logic [7:0] K_LF   = (g == 0) ? 8'h04 : 8'h50;
    localparam logic [7:0] K_RT   = (g == 0) ? 8'h07 : 8'h4f;
    localparam logic [7:0] K_FIRE = (g == 0) ? 8'h2c : 8'h28;
    localparam logic [1:0] D_RST  = (g == 0) ? 2'b11 : 2'b10;

    mv_st_t     r_state;
    mv_st_t     w_state_nxt;
    logic [7:0] r_kq;
    logic [7:0] r_kprev;
    logic [7:0] r_rcnt;
    logic [7:0] w_rcnt_nxt;
    logic [7:0] r_ccnt;
    logic [7:0] w_ccnt_nxt;
    logic [1:0] r_dir;
    logic [1:0] w_dir_nxt;
    logic [1:0] w_dcode;
    logic       w_is_dir;
    logic       w_rise;
    logic       w_move_d;
    logic       w_fire_d;
    logic       w_busy_d;
    logic       r_move;
    logic       r_fire;
    logic       r_busy;

    // Register the raw keycode and keep the previous one for fire edges
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        r_kq    <= 8'h00;
        r_kprev <= 8'h00;
      end else begin
        r_kq    <= w_key[g];
        r_kprev <= r_kq;
      end
    end

    // Decode the registered keycode into a direction code
    always_comb begin
      w_is_dir = 1'b1;
      w_dcode  = 2'b00;
      unique case (1'b1)
        (r_kq == K_UP): w_dcode = 2'b00;
        (r_kq == K_DN): w_dcode = 2'b01;
        (r_kq == K_LF): w_dcode = 2'b10;
        (r_kq == K_RT): w_dcode = 2'b11;
        default:        w_is_dir = 1'b0;
      endcase
    end

    assign w_rise = (r_kq == K_FIRE) && (r_kprev != K_FIRE);

    // State register: move FSM, counters and registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        r_state <= S_IDLE;
        r_dir   <= D_RST;
        r_rcnt  <= 8'd0;
        r_ccnt  <= 8'd0;
        r_move  <= 1'b0;
        r_fire  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_dir   <= w_dir_nxt;
        r_rcnt  <= w_rcnt_nxt;
        r_ccnt  <= w_ccnt_nxt;
        r_move  <= w_move_d;
        r_fire  <= w_fire_d;
        r_busy  <= w_busy_d;
      end
    end

    // Next state: facing, repeat pacing and fire cooldown
    always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_dir;
      w_rcnt_nxt  = r_rcnt;
      w_ccnt_nxt  = r_ccnt;
      unique case (r_state)
        S_IDLE: begin
          if (w_is_dir) begin
            w_state_nxt = S_HELD;
            w_dir_nxt   = w_dcode;
            w_rcnt_nxt  = 8'd0;
          end
        end
        S_HELD: begin
          if (!w_is_dir) begin
            w_state_nxt = S_IDLE;
            w_rcnt_nxt  = 8'd0;
          end else if (w_dcode != r_dir) begin
            w_dir_nxt  = w_dcode;
            w_rcnt_nxt = 8'd0;
          end else if (frame_tick) begin
            if (r_rcnt == 8'd0) w_rcnt_nxt = RLOAD;
            else                w_rcnt_nxt = r_rcnt - 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_fire_d)
        w_ccnt_nxt = CLOAD;
      else if (frame_tick && (r_ccnt != 8'd0))
        w_ccnt_nxt = r_ccnt - 8'd1;
    end

    // Outputs: move on a paced tick, fire on an edge outside cooldown
    always_comb begin
      w_move_d = (r_state == S_HELD) && w_is_dir &&
                 (w_dcode == r_dir) && frame_tick &&
                 (r_rcnt == 8'd0);
      w_fire_d = w_rise && (r_ccnt == 8'd0);
      w_busy_d = (w_ccnt_nxt != 8'd0);
    end

    assign w_dir[g]  = r_dir;
    assign w_move[g] = r_move;
    assign w_fire[g] = r_fire;
    assign w_busy[g] = r_busy;
  end

endmodule

// File: tb/tb_player_cmd_gen.sv
// Directed bench for player_cmd_gen.
// Linear stimulus, immediate assertions at each check point.
module tb_player_cmd_gen;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick;
  logic [7:0] keycode_p1;
  logic [7:0] keycode_p2;
  logic [1:0] p1_dir;
  logic [1:0] p2_dir;
  logic       p1_move;
  logic       p2_move;
  logic       p1_fire;
  logic       p2_fire;
  logic       p1_busy;
  logic       p2_busy;

  int n_cmp = 0;
  int n_err = 0;
  int c_m1, c_m2, c_f1, c_f2;

  always #5 Clk = ~Clk;

  player_cmd_gen #(
    .REPEAT_FRAMES  (4),
    .COOLDOWN_FRAMES(15)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_tick(frame_tick),
    .keycode_p1(keycode_p1),
    .keycode_p2(keycode_p2),
    .p1_dir    (p1_dir),
    .p2_dir    (p2_dir),
    .p1_move   (p1_move),
    .p2_move   (p2_move),
    .p1_fire   (p1_fire),
    .p2_fire   (p2_fire),
    .p1_busy   (p1_busy),
    .p2_busy   (p2_busy)
  );

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs,
                      input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs,
                      input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    c_m1 = 0;
    c_m2 = 0;
    c_f1 = 0;
    c_f2 = 0;
  endtask

  task automatic cyc(input logic ft);
    frame_tick = ft;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    c_m1 += (p1_move === 1'b1) ? 1 : 0;
    c_m2 += (p2_move === 1'b1) ? 1 : 0;
    c_f1 += (p1_fire === 1'b1) ? 1 : 0;
    c_f2 += (p2_fire === 1'b1) ? 1 : 0;
  endtask

  task automatic frame();
    repeat (9) cyc(1'b0);
    cyc(1'b1);
  endtask

  initial begin
    Reset_n    = 1'b1;
    frame_tick = 1'b0;
    keycode_p1 = 8'h00;
    keycode_p2 = 8'h00;
    clr();

    // async reset in the middle of a cycle
    #3 Reset_n = 1'b0;
    #1;
    chk2("rst_p1_dir", p1_dir, 2'b11);
    chk2("rst_p2_dir", p2_dir, 2'b10);
    chk1("rst_p1_move", p1_move, 1'b0);
    chk1("rst_p2_move", p2_move, 1'b0);
    chk1("rst_p1_fire", p1_fire, 1'b0);
    chk1("rst_p2_fire", p2_fire, 1'b0);
    chk1("rst_p1_busy", p1_busy, 1'b0);
    chk1("rst_p2_busy", p2_busy, 1'b0);
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    cyc(1'b0);
    chk2("post_rst_p1_dir", p1_dir, 2'b11);

    // p1 holds up: moves on ticks 1, 5, 9
    clr();
    keycode_p1 = 8'h1a;
    cyc(1'b0);
    chk2("up_dir_lat1", p1_dir, 2'b11);
    cyc(1'b0);
    chk2("up_dir_lat2", p1_dir, 2'b00);
    for (int f = 1; f <= 9; f++) begin
      frame();
      chk1($sformatf("up_move_t%0d", f), p1_move, (f % 4) == 1);
    end
    cyc(1'b0);
    chkn("up_move_cnt", c_m1, 3);
    chkn("up_p2_move_cnt", c_m2, 0);
    chk2("up_p2_dir", p2_dir, 2'b10);
    keycode_p1 = 8'h00;
    cyc(1'b0);
    cyc(1'b0);

    // p2 left, switch to right between ticks, release
    clr();
    keycode_p2 = 8'h50;
    cyc(1'b0);
    cyc(1'b0);
    chk2("lf_dir", p2_dir, 2'b10);
    frame();
    chk1("lf_move_t1", p2_move, 1'b1);
    repeat (4) cyc(1'b0);
    keycode_p2 = 8'h4f;
    cyc(1'b0);
    chk2("sw_dir_lat1", p2_dir, 2'b10);
    cyc(1'b0);
    chk2("sw_dir_lat2", p2_dir, 2'b11);
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    chk1("sw_move_next", p2_move, 1'b1);
    keycode_p2 = 8'h00;
    repeat (5) frame();
    chkn("sw_move_cnt", c_m2, 2);
    chk2("rel_dir_kept", p2_dir, 2'b11);
    chkn("sw_p1_move_cnt", c_m1, 0);

    // p1 holds fire for 20 ticks: one pulse, busy 15 ticks
    clr();
    keycode_p1 = 8'h2c;
    cyc(1'b0);
    chk1("fire_lat1", p1_fire, 1'b0);
    cyc(1'b0);
    chk1("fire_lat2", p1_fire, 1'b1);
    chk1("fire_busy", p1_busy, 1'b1);
    cyc(1'b0);
    chk1("fire_width", p1_fire, 1'b0);
    for (int f = 1; f <= 20; f++) begin
      frame();
      chk1($sformatf("hold_busy_t%0d", f), p1_busy, f < 15);
    end
    chkn("hold_fire_cnt", c_f1, 1);

    // re-press during cooldown is dropped, after cooldown fires
    keycode_p1 = 8'h00;
    repeat (3) cyc(1'b0);
    clr();
    keycode_p1 = 8'h2c;
    cyc(1'b0);
    cyc(1'b0);
    chk1("rp_first", p1_fire, 1'b1);
    for (int f = 1; f <= 4; f++) frame();
    keycode_p1 = 8'h00;
    repeat (3) cyc(1'b0);
    keycode_p1 = 8'h2c;
    cyc(1'b0);
    cyc(1'b0);
    chk1("rp_dropped", p1_fire, 1'b0);
    repeat (4) cyc(1'b0);
    cyc(1'b1);
    chk1("rp_busy_t5", p1_busy, 1'b1);
    for (int f = 6; f <= 15; f++) begin
      frame();
      chk1($sformatf("rp_busy_t%0d", f), p1_busy, f < 15);
    end
    chkn("rp_fire_cnt", c_f1, 1);
    keycode_p1 = 8'h00;
    repeat (3) cyc(1'b0);
    keycode_p1 = 8'h2c;
    cyc(1'b0);
    cyc(1'b0);
    chk1("rp_after", p1_fire, 1'b1);
    chkn("rp_fire_cnt2", c_f1, 2);

    // both players at once, tick on the direction entry cycle
    keycode_p1 = 8'h00;
    repeat (3) cyc(1'b0);
    clr();
    keycode_p1 = 8'h1a;
    keycode_p2 = 8'h28;
    cyc(1'b0);
    cyc(1'b1);
    chk1("both_entry_nomove", p1_move, 1'b0);
    chk1("both_p2_fire", p2_fire, 1'b1);
    chk1("both_p2_busy", p2_busy, 1'b1);
    chk2("both_p1_dir", p1_dir, 2'b00);
    frame();
    chk1("both_first_move", p1_move, 1'b1);
    chkn("both_p2_fire_cnt", c_f2, 1);
    chkn("both_p2_move_cnt", c_m2, 0);
    chk2("both_p2_dir", p2_dir, 2'b11);

    // reset mid-hold of right at rcnt=2 discards progress
    keycode_p1 = 8'h00;
    keycode_p2 = 8'h00;
    repeat (3) cyc(1'b0);
    keycode_p1 = 8'h07;
    cyc(1'b0);
    cyc(1'b0);
    chk2("rt_dir", p1_dir, 2'b11);
    frame();
    chk1("rt_move_t1", p1_move, 1'b1);
    frame();
    chk1("rt_move_t2", p1_move, 1'b0);
    #2 Reset_n = 1'b0;
    #1;
    chk2("mid_rst_p1_dir", p1_dir, 2'b11);
    chk2("mid_rst_p2_dir", p2_dir, 2'b10);
    chk1("mid_rst_p1_busy", p1_busy, 1'b0);
    chk1("mid_rst_p2_busy", p2_busy, 1'b0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    clr();
    cyc(1'b0);
    cyc(1'b0);
    chk2("rr_dir", p1_dir, 2'b11);
    chk1("rr_nomove", p1_move, 1'b0);
    frame();
    chk1("rr_first_move", p1_move, 1'b1);
    chkn("rr_move_cnt", c_m1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
